// File: rtl/sp_ctrl_pkg.sv
// sp_ctrl_pkg: shared state encoding, error bit indices and helpers for
// the signal_processing run controller.
package sp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } sp_state_e;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_TMO = 1;

  // States in which the datapath is out of reset and enabled.
  function automatic logic dp_live(input sp_state_e s);
    return (s == S_ARM) || (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/sp_ctrl_watchdog.sv
// sp_ctrl_watchdog: inactivity counter for the run controller. Counts
// enabled cycles, reloads on clear or kick, and flags expiry when the count
// reaches a nonzero limit.
module sp_ctrl_watchdog
  import sp_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  input  logic         kick,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  assign last = limit - 1'b1;

  // Expiry is raised in the cycle the count would reach the limit, so the
  // controller's error state lands exactly `limit` cycles after reload.
  assign expired = en && !kick && (limit != '0) && (cnt == last);

  // Cycle counter: reloads outside ARM/RUN, on state change and on activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clear || kick) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sp_run_controller.sv
// sp_run_controller: run sequencer for the signal_processing moving-average
// datapath. Optional watchdog timeout is built when SP_CTRL_TIMEOUT_EN is
// defined; otherwise cfg_timeout is ignored and error_code[1] stays 0.
module sp_run_controller
  import sp_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_ptos_x_ciclo,
  input  logic [31:0]      cfg_frames,
  input  logic [CNT_W-1:0] cfg_n_out,
  input  logic [31:0]      cfg_timeout,
  input  logic             src_valid,
  output logic [31:0]      sp_param_0,
  output logic [31:0]      sp_param_1,
  output logic             sp_reset_n,
  output logic             sp_enable,
  output logic             sp_data_in_valid,
  input  logic             sp_data_out_valid,
  input  logic             sp_ready,
  input  logic             sp_fifo_full,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] out_count
);

  sp_state_e        st;
  sp_state_e        nxt;
  logic [31:0]      phase;
  logic [CNT_W-1:0] n_out_r;
  logic [CNT_W-1:0] n_last;
  logic             start_ok;
  logic             abort_hit;
  logic             ovf_hit;
  logic             tmo_hit;
  logic             last_out;
  logic             load_end;
  logic             drain_end;

  assign state            = st;
  assign sp_data_in_valid = (st == S_RUN) && src_valid;

  assign n_last    = n_out_r - 1'b1;
  assign abort_hit = abort && (st != S_IDLE);
  assign ovf_hit   = dp_live(st) && sp_fifo_full;
  assign last_out  = (st == S_RUN) && sp_data_out_valid &&
                     (n_out_r != '0) && (out_count == n_last);
  assign load_end  = (phase == LOAD_CYCLES - 1);
  assign drain_end = (phase == DRAIN_CYCLES - 1);

`ifdef SP_CTRL_TIMEOUT_EN
  logic [31:0] timeout_r;

  // Watchdog limit is captured with the rest of the run configuration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_r <= '0;
    end else if (start_ok) begin
      timeout_r <= cfg_timeout;
    end
  end

  sp_ctrl_watchdog #(
    .W (32)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      ((st == S_ARM) || (st == S_RUN)),
    .clear   (nxt != st),
    .kick    (sp_data_out_valid),
    .limit   (timeout_r),
    .expired (tmo_hit)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^cfg_timeout;
  assign tmo_hit        = 1'b0;
`endif

  // Next-state selection; later assignments override earlier ones, so the
  // order below encodes priority: abort, then error, then count/start.
  always_comb begin
    nxt      = st;
    start_ok = 1'b0;
    case (st)
      S_IDLE: begin
        if (start) begin
          nxt      = S_LOAD;
          start_ok = 1'b1;
        end
      end
      S_LOAD:  if (load_end)  nxt = S_ARM;
      S_ARM:   if (sp_ready)  nxt = S_RUN;
      S_RUN:   if (last_out)  nxt = S_DRAIN;
      S_DRAIN: if (drain_end) nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          nxt      = S_LOAD;
          start_ok = 1'b1;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (start) begin
          nxt      = S_LOAD;
          start_ok = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (ovf_hit || tmo_hit) begin
      nxt = S_ERROR;
    end
    if (abort_hit) begin
      nxt      = S_IDLE;
      start_ok = 1'b0;
    end
  end

  // State, registered outputs, configuration capture and output counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      phase      <= '0;
      n_out_r    <= '0;
      sp_param_0 <= '0;
      sp_param_1 <= '0;
      sp_reset_n <= 1'b0;
      sp_enable  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= '0;
      out_count  <= '0;
    end else begin
      st         <= nxt;
      phase      <= ((nxt != st) || !((st == S_LOAD) || (st == S_DRAIN)))
                    ? '0 : phase + 32'd1;
      sp_reset_n <= dp_live(nxt);
      sp_enable  <= dp_live(nxt);
      busy       <= dp_live(nxt) || (nxt == S_LOAD);
      done       <= (nxt == S_DONE);
      error      <= (nxt == S_ERROR);
      if (start_ok) begin
        sp_param_0 <= cfg_ptos_x_ciclo;
        sp_param_1 <= cfg_frames;
        n_out_r    <= cfg_n_out;
        out_count  <= '0;
        error_code <= '0;
      end else begin
        if (((st == S_RUN) || (st == S_DRAIN)) && sp_data_out_valid &&
            (out_count != '1)) begin
          out_count <= out_count + 1'b1;
        end
        if (!abort_hit) begin
          if (ovf_hit) error_code[ERR_OVF] <= 1'b1;
          if (tmo_hit) error_code[ERR_TMO] <= 1'b1;
        end
      end
    end
  end

endmodule
